// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch sequencer and its instruction decoder.
//   - Opcode constants (instruction bits [15:12]).
//   - PC unit mode encodings driven onto the PC unit's M input.
//   - Fetch sequencer state encoding.
package cpu_defs_pkg;

  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BACK = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] PCM_INC  = 2'b00;
  localparam logic [1:0] PCM_DEC  = 2'b01;
  localparam logic [1:0] PCM_LOAD = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StStep,
    StHalt,
    StErr
  } fetch_state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder for the fetch sequencer.
// Ports:
//   i_ir        instruction register contents
//   i_zero_flag ALU zero flag, selects taken/not-taken for JZ
//   o_mode      PC unit mode (inc / dec / load)
//   o_target    PC load target (imm field of the instruction)
//   o_is_halt   instruction is HALT
module instr_decode
  import cpu_defs_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] i_ir,
  input  logic               i_zero_flag,
  output logic [1:0]         o_mode,
  output logic [ADDR_W-1:0]  o_target,
  output logic               o_is_halt
);

  logic [3:0] w_op;
  // The register field is not needed for PC sequencing.
  logic       w_unused_reg_field;

  assign w_op               = i_ir[INSTR_W-1 -: 4];
  assign o_target           = i_ir[ADDR_W-1:0];
  assign w_unused_reg_field = ^i_ir[INSTR_W-5:ADDR_W];

  always_comb begin
    o_mode    = PCM_INC;
    o_is_halt = 1'b0;
    case (w_op)
      OP_JMP:  o_mode    = PCM_LOAD;
      OP_BACK: o_mode    = PCM_DEC;
      OP_JZ:   o_mode    = i_zero_flag ? PCM_LOAD : PCM_INC;
      OP_HALT: o_is_halt = 1'b1;
      default: o_mode    = PCM_INC;
    endcase
  end

endmodule

// File: rtl/ir_fetch_ctrl.sv
// Fetch sequencer and instruction register wrapped around the PC unit.
// Fetches from instruction memory at the current PC, latches IR, decodes the
// opcode into PC unit mode/target and issues a one-cycle step strobe.
// Ports:
//   i_clk, i_clr      clock (rising edge), asynchronous active-high reset
//   i_run             level; sequencer may start/continue fetching
//   i_zero_flag       ALU zero flag for JZ
//   i_pc              current PC from the PC unit
//   o_mem_req/addr    instruction memory read request and address
//   i_mem_rdata/ack   read data and its valid strobe
//   o_ir, o_ir_valid  instruction register and new-instruction pulse
//   o_pc_mode/target  PC unit mode and load data, held between decodes
//   o_pc_step         one-cycle strobe: PC unit applies o_pc_mode
//   o_halted, o_err   sticky HALT / fetch-timeout flags
module ir_fetch_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_clr,
  input  logic               i_run,
  input  logic               i_zero_flag,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_mem_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [INSTR_W-1:0] i_mem_rdata,
  input  logic               i_mem_ack,
  output logic [INSTR_W-1:0] o_ir,
  output logic               o_ir_valid,
  output logic [1:0]         o_pc_mode,
  output logic [ADDR_W-1:0]  o_pc_target,
  output logic               o_pc_step,
  output logic               o_halted,
  output logic               o_err
);

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  fetch_state_e        r_state;
  logic [CntW-1:0]     r_cnt;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_ir_valid;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [1:0]          r_pc_mode;
  logic [ADDR_W-1:0]   r_pc_target;
  logic                r_pc_step;
  logic                r_halted;
  logic                r_err;

  logic [1:0]          w_mode;
  logic [ADDR_W-1:0]   w_target;
  logic                w_is_halt;

  instr_decode #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_decode (
    .i_ir        (r_ir),
    .i_zero_flag (i_zero_flag),
    .o_mode      (w_mode),
    .o_target    (w_target),
    .o_is_halt   (w_is_halt)
  );

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_ir        <= '0;
      r_ir_valid  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_pc_mode   <= PCM_INC;
      r_pc_target <= '0;
      r_pc_step   <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Single-cycle pulses fall back to zero unless re-raised below.
      r_ir_valid <= 1'b0;
      r_pc_step  <= 1'b0;
      case (r_state)
        StIdle, StStep: begin
          // STEP->FETCH samples the PC the unit updated on STEP's falling edge.
          if (i_run) begin
            r_state    <= StFetch;
            r_mem_addr <= i_pc;
            r_mem_req  <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_state <= StIdle;
          end
        end
        StFetch: begin
          // Ack wins over timeout on the final allowed cycle.
          if (i_mem_ack) begin
            r_ir       <= i_mem_rdata;
            r_ir_valid <= 1'b1;
            r_mem_req  <= 1'b0;
            r_state    <= StDecode;
          end else if (r_cnt == CntLast) begin
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= StErr;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDecode: begin
          r_pc_mode   <= w_mode;
          r_pc_target <= w_target;
          if (w_is_halt) begin
            r_halted <= 1'b1;
            r_state  <= StHalt;
          end else begin
            r_pc_step <= 1'b1;
            r_state   <= StStep;
          end
        end
        StHalt, StErr: r_state <= r_state;
        default:       r_state <= StIdle;
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_ir        = r_ir;
  assign o_ir_valid  = r_ir_valid;
  assign o_pc_mode   = r_pc_mode;
  assign o_pc_target = r_pc_target;
  assign o_pc_step   = r_pc_step;
  assign o_halted    = r_halted;
  assign o_err       = r_err;

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Self-checking bench for ir_fetch_ctrl: directed scenarios followed by a
// randomized program run against an instruction-level PC model.
module tb_ir_fetch_ctrl;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run = 1'b0;
  logic        zero_flag = 1'b0;
  logic [7:0]  pc;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ack = 1'b0;
  logic [15:0] ir;
  logic        ir_valid;
  logic [1:0]  pc_mode;
  logic [7:0]  pc_target;
  logic        pc_step;
  logic        halted;
  logic        err;

  int checks = 0;
  int errors = 0;

  ir_fetch_ctrl #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_clr       (clr),
    .i_run       (run),
    .i_zero_flag (zero_flag),
    .i_pc        (pc),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack),
    .o_ir        (ir),
    .o_ir_valid  (ir_valid),
    .o_pc_mode   (pc_mode),
    .o_pc_target (pc_target),
    .o_pc_step   (pc_step),
    .o_halted    (halted),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // PC unit: applies the mode on the falling edge inside a step strobe.
  // The stimulus can overwrite the PC by bumping seed_gen.
  logic [7:0] pc_seed = 8'h00;
  int         seed_gen = 0;
  int         seen_gen = 0;
  always @(negedge clk) begin
    if (seed_gen != seen_gen) begin
      pc       <= pc_seed;
      seen_gen <= seed_gen;
    end else if (pc_step) begin
      case (pc_mode)
        2'b00:   pc <= pc + 8'd1;
        2'b01:   pc <= pc - 8'd1;
        2'b10:   pc <= pc_target;
        default: pc <= pc;
      endcase
    end
  end

  // Instruction memory: acks rsp_delay cycles into a request.
  logic [15:0] mem [256];
  int          rsp_delay = 0;
  logic        stray_ack = 1'b0;
  int          wait_cnt = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= rsp_delay) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem[mem_addr];
      end else begin
        mem_ack   <= 1'b0;
        mem_rdata <= 16'hDEAD;
      end
      wait_cnt <= wait_cnt + 1;
    end else begin
      mem_ack   <= stray_ack;
      mem_rdata <= 16'hBEEF;
      wait_cnt  <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ir"},        32'(ir),        32'h0);
    check({tag, "_ir_valid"},  32'(ir_valid),  32'h0);
    check({tag, "_mem_req"},   32'(mem_req),   32'h0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_pc_mode"},   32'(pc_mode),   32'h0);
    check({tag, "_pc_target"}, 32'(pc_target), 32'h0);
    check({tag, "_pc_step"},   32'(pc_step),   32'h0);
    check({tag, "_halted"},    32'(halted),    32'h0);
    check({tag, "_err"},       32'(err),       32'h0);
  endtask

  // Instruction-level reference: what the PC should become after one instruction.
  function automatic void model(input logic [15:0] instr, input logic [7:0] cur,
                                input logic zf, output logic [1:0] mode,
                                output logic [7:0] nxt);
    logic [3:0] op;
    logic [7:0] imm;
    op  = instr[15:12];
    imm = instr[7:0];
    mode = 2'b00;
    nxt  = cur + 8'd1;
    if (op == 4'hA || (op == 4'hC && zf)) begin
      mode = 2'b10;
      nxt  = imm;
    end else if (op == 4'hB) begin
      mode = 2'b01;
      nxt  = cur - 8'd1;
    end
  endfunction

  initial begin
    logic [7:0]  exp_pc;
    logic [7:0]  exp_next;
    logic [1:0]  exp_mode;
    logic [3:0]  op_r;
    logic [15:0] instr;
    logic        zf;
    int          d;
    int          n;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    pc_seed = 8'h00;
    seed_gen++;
    repeat (2) tick();
    check_reset("reset");

    // Straight-line program: INC, JMP, JZ not taken, JZ taken, HALT.
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'hA05C;
    mem[8'h5C] = 16'hC010;
    mem[8'h5D] = 16'hC010;
    mem[8'h10] = 16'hF000;
    rsp_delay = 0;
    clr = 1'b0;
    run = 1'b1;
    tick();
    check("f0_req",   32'(mem_req),  32'h1);
    check("f0_addr",  32'(mem_addr), 32'h00);
    tick();
    check("d0_ir",    32'(ir),       32'h1234);
    check("d0_valid", 32'(ir_valid), 32'h1);
    tick();
    check("s0_step",  32'(pc_step),  32'h1);
    check("s0_mode",  32'(pc_mode),  32'h0);
    check("s0_valid", 32'(ir_valid), 32'h0);
    tick();
    check("f1_step",  32'(pc_step),  32'h0);
    check("f1_req",   32'(mem_req),  32'h1);
    check("f1_addr",  32'(mem_addr), 32'h01);
    tick();
    check("jmp_ir",   32'(ir),       32'hA05C);
    tick();
    check("jmp_step",   32'(pc_step),   32'h1);
    check("jmp_mode",   32'(pc_mode),   32'h2);
    check("jmp_target", 32'(pc_target), 32'h5C);
    @(negedge clk);
    #1;
    check("jmp_mode_stable",   32'(pc_mode),   32'h2);
    check("jmp_target_stable", 32'(pc_target), 32'h5C);
    tick();
    check("jmp_fetch_addr", 32'(mem_addr), 32'h5C);
    zero_flag = 1'b0;
    tick();
    check("jz0_ir", 32'(ir), 32'hC010);
    tick();
    check("jz0_mode", 32'(pc_mode), 32'h0);
    tick();
    check("jz0_fetch_addr", 32'(mem_addr), 32'h5D);
    zero_flag = 1'b1;
    tick();
    tick();
    check("jz1_mode",   32'(pc_mode),   32'h2);
    check("jz1_target", 32'(pc_target), 32'h10);
    tick();
    check("jz1_fetch_addr", 32'(mem_addr), 32'h10);
    zero_flag = 1'b0;
    tick();
    check("halt_ir", 32'(ir), 32'hF000);
    tick();
    check("halt_flag", 32'(halted),  32'h1);
    check("halt_step", 32'(pc_step), 32'h0);
    // Stray acks while halted must not touch IR or restart fetching.
    stray_ack = 1'b1;
    repeat (4) begin
      tick();
      check("halt_req_low",  32'(mem_req), 32'h0);
      check("halt_no_step",  32'(pc_step), 32'h0);
      check("halt_ir_keep",  32'(ir),      32'hF000);
    end
    stray_ack = 1'b0;
    clr = 1'b1;
    #1;
    check_reset("halt_clr");

    // run dropped during DECODE: instruction completes, then IDLE.
    pc_seed = 8'h40;
    seed_gen++;
    mem[8'h40] = 16'h0777;
    mem[8'h41] = 16'h0888;
    tick();
    clr = 1'b0;
    tick();
    check("rd_addr", 32'(mem_addr), 32'h40);
    tick();
    check("rd_valid", 32'(ir_valid), 32'h1);
    run = 1'b0;
    tick();
    check("rd_step", 32'(pc_step), 32'h1);
    tick();
    check("rd_idle_req",  32'(mem_req), 32'h0);
    check("rd_idle_step", 32'(pc_step), 32'h0);
    tick();
    check("rd_idle_req2", 32'(mem_req), 32'h0);
    run = 1'b1;
    tick();
    check("rd_resume_addr", 32'(mem_addr), 32'h41);
    tick();
    check("rd_resume_ir", 32'(ir), 32'h0888);
    run = 1'b0;
    repeat (2) tick();

    // Fetch timeout: no ack for TIMEOUT cycles.
    clr = 1'b1;
    pc_seed = 8'h20;
    seed_gen++;
    mem[8'h20] = 16'h1111;
    rsp_delay = 1000;
    tick();
    clr = 1'b0;
    run = 1'b1;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("to_last_err", 32'(err),     32'h0);
    check("to_last_req", 32'(mem_req), 32'h1);
    tick();
    check("to_err", 32'(err),     32'h1);
    check("to_req", 32'(mem_req), 32'h0);
    repeat (3) tick();
    check("to_err_sticky", 32'(err),     32'h1);
    check("to_req_sticky", 32'(mem_req), 32'h0);

    // Ack on the last allowed cycle still decodes normally.
    clr = 1'b1;
    #1;
    check("to_clr_err", 32'(err), 32'h0);
    rsp_delay = TIMEOUT - 1;
    tick();
    clr = 1'b0;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("late_ack_req", 32'(mem_req), 32'h1);
    tick();
    check("late_ack_valid", 32'(ir_valid), 32'h1);
    check("late_ack_ir",    32'(ir),       32'h1111);
    check("late_ack_err",   32'(err),      32'h0);
    run = 1'b0;
    repeat (2) tick();

    // clr mid-FETCH while the ack is on the bus.
    clr = 1'b1;
    pc_seed = 8'h30;
    seed_gen++;
    mem[8'h30] = 16'h5A5A;
    rsp_delay = 0;
    tick();
    clr = 1'b0;
    run = 1'b1;
    tick();
    check("cm_req",  32'(mem_req),  32'h1);
    check("cm_addr", 32'(mem_addr), 32'h30);
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    check_reset("cm_async");
    run = 1'b0;
    #1;
    clr = 1'b0;
    repeat (2) begin
      tick();
      check("cm_ir",    32'(ir),       32'h0);
      check("cm_valid", 32'(ir_valid), 32'h0);
      check("cm_req2",  32'(mem_req),  32'h0);
    end

    // Randomized program against the instruction-level model.
    clr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      op_r = 4'($urandom_range(0, 12));
      mem[i] = {op_r, 12'($urandom)};
    end
    exp_pc  = 8'($urandom_range(0, 255));
    pc_seed = exp_pc;
    seed_gen++;
    tick();
    clr = 1'b0;
    run = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d  = int'($urandom_range(0, 4));
      zf = 1'($urandom_range(0, 1));
      rsp_delay = d;
      zero_flag = zf;
      n = 0;
      do begin
        tick();
        n++;
      end while (!ir_valid && n < 40);
      check("rnd_valid",   32'(ir_valid), 32'h1);
      check("rnd_latency", 32'(n),        32'(d + 2));
      check("rnd_addr",    32'(mem_addr), 32'(exp_pc));
      instr = mem[exp_pc];
      check("rnd_ir",      32'(ir),       32'(instr));
      model(instr, exp_pc, zf, exp_mode, exp_next);
      tick();
      check("rnd_step",  32'(pc_step),  32'h1);
      check("rnd_mode",  32'(pc_mode),  32'(exp_mode));
      check("rnd_pulse", 32'(ir_valid), 32'h0);
      if (exp_mode == 2'b10) check("rnd_target", 32'(pc_target), 32'(instr[7:0]));
      exp_pc = exp_next;
    end
    run = 1'b0;
    repeat (3) tick();
    check("rnd_end_idle", 32'(mem_req), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
